rf_write_arbiter: RTL

- Shares the single register-file write port between two writeback sources: port 0 (ALU writeback) and port 1 (memory/load writeback).
- Each source requests with a req/ack handshake. The arbiter grants one source at a time, round-robin, and drives write_en/write_addr/write_data until reg_ack returns.
- Suppresses writes to the hard-wired zero register.
- Flags a register file that never acknowledges, via a timeout.

---
 rtl/rf_write_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between
// ALU and load writeback, with zero-register suppression and ack timeout.
module rf_write_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int ZERO_REG_RO = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] rd0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] rd1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic              reg_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] pend_addr,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_n;
  logic              last_grant, last_grant_n;
  logic              gnt, gnt_n;
  logic              ack0_n, ack1_n;
  logic              we_n, busy_n, terr_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n;
  logic [7:0]        cnt, cnt_n;

  logic              pick;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  // Under contention the port that did not win last time goes first.
  assign pick     = (req0 & req1) ? ~last_grant : req1;
  assign sel_rd   = pick ? rd1 : rd0;
  assign sel_data = pick ? data1 : data0;
  assign pend_addr = write_addr;

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    gnt_n        = gnt;
    ack0_n       = 1'b0;
    ack1_n       = 1'b0;
    we_n         = write_en;
    busy_n       = busy;
    terr_n       = timeout_err;
    addr_n       = write_addr;
    data_n       = write_data;
    cnt_n        = cnt;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt_n        = pick;
          last_grant_n = pick;
          addr_n       = sel_rd;
          data_n       = sel_data;
          busy_n       = 1'b1;
          if ((ZERO_REG_RO != 0) && (sel_rd == '0)) begin
            state_n = DONE;
          end else begin
            we_n    = 1'b1;
            cnt_n   = '0;
            state_n = WRITE;
          end
        end
      end
      WRITE: begin
        cnt_n = cnt + 8'd1;
        if (reg_ack) begin
          we_n    = 1'b0;
          state_n = DONE;
        end else if (cnt == TMO_LAST) begin
          // Still ack the requester so the pipeline cannot hang.
          we_n    = 1'b0;
          terr_n  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        ack0_n  = ~gnt;
        ack1_n  = gnt;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      write_en    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      gnt         <= gnt_n;
      ack0        <= ack0_n;
      ack1        <= ack1_n;
      write_en    <= we_n;
      busy        <= busy_n;
      timeout_err <= terr_n;
      write_addr  <= addr_n;
      write_data  <= data_n;
      cnt         <= cnt_n;
    end
  end

endmodule
